rx_line_collector: RTL and testbench

Parametrised successor to the receive-side line collector. It takes per-line packet payload words from the Rx deframer and writes them into the frame buffer as linear write-enable/address/data. A watchdog zero-pads any line that does not arrive in time. It keeps a per-line "received" bitmap plus running counts for the display/link controller. Line geometry, data width, timeout and padding mode are parameters.

---
 rtl/rx_collect_pkg.sv | 33 +++
 rtl/rx_line_bitmap.sv | 41 ++++
 rtl/rx_line_collector.sv | 180 ++++++++++++++++++
 tb/tb_rx_line_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_collect_pkg.sv
// Shared types and width/geometry helpers for the receive-side line collector.
package rx_collect_pkg;

  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_PAD  = 2'd1,
    ST_FULL = 2'd2
  } rx_state_e;

  function automatic int unsigned calc_line_w(input int unsigned num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

  function automatic int unsigned calc_word_w(input int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned num_lines,
                                              input int unsigned line_words);
    return $clog2(num_lines * line_words + 1);
  endfunction

  function automatic int unsigned calc_wd_w(input int unsigned wd_timeout);
    return (wd_timeout > 1) ? $clog2(wd_timeout) : 1;
  endfunction

  // First frame-buffer address of a line; line_words is a constant so this is a fixed multiply.
  function automatic int unsigned line_base(input int unsigned idx,
                                            input int unsigned line_words);
    return idx * line_words;
  endfunction

endpackage

// File: rtl/rx_line_bitmap.sv
// Per-line "received" flags with an incrementally maintained population count.
module rx_line_bitmap
  import rx_collect_pkg::*;
#(
  parameter  int unsigned NUM_LINES = 480,
  localparam int unsigned LINE_W    = calc_line_w(NUM_LINES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_all,
  input  logic              set_en,
  input  logic              clr_en,
  input  logic [LINE_W-1:0] idx,
  input  logic [LINE_W-1:0] query_idx,
  output logic              hit_c,
  output logic [LINE_W:0]   count
);

  logic [NUM_LINES-1:0] flags;
  logic                 idx_ok;
  logic                 cur;

  assign idx_ok = (32'(idx) < NUM_LINES);
  assign cur    = idx_ok && flags[idx];
  assign hit_c  = (32'(query_idx) < NUM_LINES) && flags[query_idx];

  // Count only moves when a flag actually changes, so repeated set/clear is harmless.
  always_ff @(posedge clk) begin
    if (!rstn || clr_all) begin
      flags <= '0;
      count <= '0;
    end else if (set_en && idx_ok) begin
      flags[idx] <= 1'b1;
      if (!cur) count <= count + (LINE_W+1)'(1);
    end else if (clr_en && idx_ok) begin
      flags[idx] <= 1'b0;
      if (cur) count <= count - (LINE_W+1)'(1);
    end
  end

endmodule

// File: rtl/rx_line_collector.sv
// Collects per-line Rx payload words into linear frame-buffer writes, with a
// watchdog that zero-pads (or skips) lines that never arrive.
module rx_line_collector
  import rx_collect_pkg::*;
#(
  parameter  int unsigned DATA_W     = 12,
  parameter  int unsigned LINE_WORDS = 80,
  parameter  int unsigned NUM_LINES  = 480,
  parameter  int unsigned WD_TIMEOUT = 144640,
  parameter  int unsigned PAD_EN     = 1,
  localparam int unsigned LINE_W     = calc_line_w(NUM_LINES),
  localparam int unsigned ADDR_W     = calc_addr_w(NUM_LINES, LINE_WORDS),
  localparam int unsigned WD_W       = calc_wd_w(WD_TIMEOUT)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic [LINE_W-1:0] rx_line,
  input  logic              rx_line_valid,
  input  logic              frame_rst,
  input  logic [LINE_W-1:0] line_num,
  output logic              received_pkt,
  output logic              wm_en,
  output logic [ADDR_W-1:0] wm_addr,
  output logic [DATA_W-1:0] wm_data,
  output logic              pad_active,
  output logic              frame_done,
  output logic [LINE_W:0]   lines_ok,
  output logic              rx_drop
);

  localparam int unsigned WORD_W = calc_word_w(LINE_WORDS);

  rx_state_e         state, state_nxt;
  logic [LINE_W-1:0] line_idx, line_nxt;
  logic [WORD_W-1:0] word_idx, word_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  logic              drop_nxt;
  logic              wen_nxt;
  logic [ADDR_W-1:0] waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              bm_set, bm_clr, bm_clr_all;

  logic [ADDR_W-1:0] cur_addr;
  logic [LINE_W-1:0] line_inc;
  logic              last_word;
  logic              last_line;
  logic              wd_expired;

  assign cur_addr   = ADDR_W'(line_base(32'(line_idx), LINE_WORDS) + 32'(word_idx));
  assign line_inc   = line_idx + LINE_W'(1);
  assign last_word  = (word_idx == WORD_W'(LINE_WORDS - 1));
  assign last_line  = (line_idx == LINE_W'(NUM_LINES - 1));
  assign wd_expired = (wd_cnt == WD_W'(WD_TIMEOUT - 1));

  rx_line_bitmap #(
    .NUM_LINES (NUM_LINES)
  ) u_bitmap (
    .clk       (clk),
    .rstn      (rstn),
    .clr_all   (bm_clr_all),
    .set_en    (bm_set),
    .clr_en    (bm_clr),
    .idx       (line_idx),
    .query_idx (line_num),
    .hit_c     (received_pkt),
    .count     (lines_ok)
  );

  // Next-state and next-output decode; priority: frame_rst > header > data > watchdog.
  always_comb begin
    state_nxt  = state;
    line_nxt   = line_idx;
    word_nxt   = word_idx;
    wd_nxt     = wd_cnt;
    drop_nxt   = rx_drop;
    wen_nxt    = 1'b0;
    waddr_nxt  = wm_addr;
    wdata_nxt  = wm_data;
    bm_set     = 1'b0;
    bm_clr     = 1'b0;
    bm_clr_all = 1'b0;

    if (frame_rst) begin
      state_nxt  = ST_RECV;
      line_nxt   = '0;
      word_nxt   = '0;
      wd_nxt     = '0;
      drop_nxt   = 1'b0;
      bm_clr_all = 1'b1;
    end else if (rx_line_valid) begin
      line_nxt  = rx_line;
      word_nxt  = '0;
      wd_nxt    = '0;
      state_nxt = (32'(rx_line) >= NUM_LINES) ? ST_FULL : ST_RECV;
    end else begin
      case (state)
        ST_RECV: begin
          if (rx_valid) begin
            wen_nxt   = 1'b1;
            waddr_nxt = cur_addr;
            wdata_nxt = rx_data;
            wd_nxt    = '0;
            if (last_word) begin
              bm_set   = 1'b1;
              word_nxt = '0;
              line_nxt = line_inc;
              if (last_line) state_nxt = ST_FULL;
            end else begin
              word_nxt = word_idx + WORD_W'(1);
            end
          end else if (wd_expired) begin
            word_nxt = '0;
            wd_nxt   = '0;
            if (PAD_EN != 0) begin
              state_nxt = ST_PAD;
            end else begin
              bm_clr   = 1'b1;
              line_nxt = line_inc;
              if (last_line) state_nxt = ST_FULL;
            end
          end else begin
            wd_nxt = wd_cnt + WD_W'(1);
          end
        end
        ST_PAD: begin
          // The whole line is rewritten, so partial data from a late line never survives.
          wen_nxt   = 1'b1;
          waddr_nxt = cur_addr;
          wdata_nxt = '0;
          bm_clr    = 1'b1;
          if (rx_valid) drop_nxt = 1'b1;
          if (last_word) begin
            word_nxt  = '0;
            wd_nxt    = '0;
            line_nxt  = line_inc;
            state_nxt = last_line ? ST_FULL : ST_RECV;
          end else begin
            word_nxt = word_idx + WORD_W'(1);
          end
        end
        ST_FULL: begin
          wd_nxt = '0;
          if (rx_valid) drop_nxt = 1'b1;
        end
        default: begin
          state_nxt = ST_RECV;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_RECV;
      line_idx   <= '0;
      word_idx   <= '0;
      wd_cnt     <= '0;
      rx_drop    <= 1'b0;
      wm_en      <= 1'b0;
      wm_addr    <= '0;
      wm_data    <= '0;
      pad_active <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      line_idx   <= line_nxt;
      word_idx   <= word_nxt;
      wd_cnt     <= wd_nxt;
      rx_drop    <= drop_nxt;
      wm_en      <= wen_nxt;
      wm_addr    <= waddr_nxt;
      wm_data    <= wdata_nxt;
      pad_active <= (state_nxt == ST_PAD);
      frame_done <= (state_nxt == ST_FULL);
    end
  end

endmodule

// File: tb/tb_rx_line_collector.sv
// Bench for rx_line_collector: two instances (skip / zero-pad) on shared stimulus,
// directed scenarios plus random traffic against a line-level reference model.
module tb_rx_line_collector;

  localparam int LW = 4;
  localparam int NL = 4;
  localparam int WD = 10;

  logic        clk;
  logic        rstn;
  logic [11:0] rx_data;
  logic        rx_valid;
  logic [1:0]  rx_line;
  logic        rx_line_valid;
  logic        frame_rst;
  logic [1:0]  line_num;

  logic        d0_rp, d0_wen, d0_pad, d0_done, d0_drop;
  logic [4:0]  d0_addr;
  logic [11:0] d0_data;
  logic [2:0]  d0_lok;
  logic        d1_rp, d1_wen, d1_pad, d1_done, d1_drop;
  logic [4:0]  d1_addr;
  logic [11:0] d1_data;
  logic [2:0]  d1_lok;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = skip lost lines, index 1 = zero-pad them.
  int m_line[2];
  int m_word[2];
  int m_idle[2];
  bit m_pad[2];
  bit m_full[2];
  bit m_drop[2];
  bit m_got[2][NL];
  bit e_wen[2];
  int e_addr[2];
  int e_data[2];

  rx_line_collector #(
    .DATA_W(12), .LINE_WORDS(LW), .NUM_LINES(NL), .WD_TIMEOUT(WD), .PAD_EN(0)
  ) dut_skip (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_line(rx_line), .rx_line_valid(rx_line_valid), .frame_rst(frame_rst),
    .line_num(line_num), .received_pkt(d0_rp), .wm_en(d0_wen), .wm_addr(d0_addr),
    .wm_data(d0_data), .pad_active(d0_pad), .frame_done(d0_done),
    .lines_ok(d0_lok), .rx_drop(d0_drop)
  );

  rx_line_collector #(
    .DATA_W(12), .LINE_WORDS(LW), .NUM_LINES(NL), .WD_TIMEOUT(WD), .PAD_EN(1)
  ) dut_pad (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_line(rx_line), .rx_line_valid(rx_line_valid), .frame_rst(frame_rst),
    .line_num(line_num), .received_pkt(d1_rp), .wm_en(d1_wen), .wm_addr(d1_addr),
    .wm_data(d1_data), .pad_active(d1_pad), .frame_done(d1_done),
    .lines_ok(d1_lok), .rx_drop(d1_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_got(input int m);
    int c = 0;
    for (int i = 0; i < NL; i++) c += int'(m_got[m][i]);
    return c;
  endfunction

  task automatic next_line(input int m);
    m_line[m]++;
    m_word[m] = 0;
    m_idle[m] = 0;
    if (m_line[m] == NL) m_full[m] = 1'b1;
  endtask

  // One clock of the collector described by its rules, not by its registers.
  task automatic model_step(input int m);
    e_wen[m] = 1'b0;
    if (!rstn || frame_rst) begin
      m_line[m] = 0; m_word[m] = 0; m_idle[m] = 0;
      m_pad[m] = 1'b0; m_full[m] = 1'b0; m_drop[m] = 1'b0;
      for (int i = 0; i < NL; i++) m_got[m][i] = 1'b0;
      if (!rstn) begin e_addr[m] = 0; e_data[m] = 0; end
    end else if (rx_line_valid) begin
      m_line[m] = int'(rx_line); m_word[m] = 0; m_idle[m] = 0;
      m_pad[m] = 1'b0;
      m_full[m] = (int'(rx_line) >= NL);
    end else if (m_full[m]) begin
      if (rx_valid) m_drop[m] = 1'b1;
    end else if (m_pad[m]) begin
      e_wen[m] = 1'b1; e_addr[m] = m_line[m] * LW + m_word[m]; e_data[m] = 0;
      m_got[m][m_line[m]] = 1'b0;
      if (rx_valid) m_drop[m] = 1'b1;
      m_word[m]++;
      if (m_word[m] == LW) begin m_pad[m] = 1'b0; next_line(m); end
    end else if (rx_valid) begin
      e_wen[m] = 1'b1; e_addr[m] = m_line[m] * LW + m_word[m]; e_data[m] = int'(rx_data);
      m_idle[m] = 0;
      m_word[m]++;
      if (m_word[m] == LW) begin m_got[m][m_line[m]] = 1'b1; next_line(m); end
    end else begin
      m_idle[m]++;
      if (m_idle[m] == WD) begin
        m_idle[m] = 0;
        m_word[m] = 0;
        if (m == 1) m_pad[m] = 1'b1;
        else begin m_got[m][m_line[m]] = 1'b0; next_line(m); end
      end
    end
  endtask

  task automatic compare_dut(input int m, input logic wen, input logic [4:0] addr,
                             input logic [11:0] data, input logic pad, input logic done,
                             input logic [2:0] lok, input logic drop, input logic rp);
    chk($sformatf("d%0d_wm_en", m), 32'(wen), 32'(e_wen[m]));
    if (e_wen[m]) begin
      chk($sformatf("d%0d_wm_addr", m), 32'(addr), 32'(e_addr[m]));
      chk($sformatf("d%0d_wm_data", m), 32'(data), 32'(e_data[m]));
    end
    chk($sformatf("d%0d_pad_active", m), 32'(pad), 32'(m_pad[m]));
    chk($sformatf("d%0d_frame_done", m), 32'(done), 32'(m_full[m]));
    chk($sformatf("d%0d_lines_ok", m), 32'(lok), 32'(count_got(m)));
    chk($sformatf("d%0d_rx_drop", m), 32'(drop), 32'(m_drop[m]));
    chk($sformatf("d%0d_received_pkt", m), 32'(rp), 32'(m_got[m][line_num]));
  endtask

  // Drive one cycle of inputs, advance the model, then sample both DUTs after the edge.
  task automatic cyc(input bit rv, input int d, input bit lv, input int ln, input bit fr,
                     input int q);
    rx_valid      = rv;
    rx_data       = 12'(d);
    rx_line_valid = lv;
    rx_line       = 2'(ln);
    frame_rst     = fr;
    line_num      = (q >= 0) ? 2'(q) : 2'($urandom_range(0, NL - 1));
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_dut(0, d0_wen, d0_addr, d0_data, d0_pad, d0_done, d0_lok, d0_drop, d0_rp);
    compare_dut(1, d1_wen, d1_addr, d1_data, d1_pad, d1_done, d1_lok, d1_drop, d1_rp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic send_line(input int first_addr, input int base);
    for (int k = 0; k < LW; k++) begin
      cyc(1'b1, base + k, 1'b0, 0, 1'b0, -1);
      chk("line_addr_skip", 32'(d0_addr), 32'(first_addr + k));
      chk("line_addr_pad", 32'(d1_addr), 32'(first_addr + k));
      chk("line_data_pad", 32'(d1_data), 32'(base + k));
    end
  endtask

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_line_valid = 1'b0;
    rx_line = '0; frame_rst = 1'b0; line_num = '0;

    // Reset values
    idle(2);
    chk("rst_wm_en", 32'(d1_wen), 32'(0));
    chk("rst_wm_addr", 32'(d1_addr), 32'(0));
    chk("rst_wm_data", 32'(d1_data), 32'(0));
    chk("rst_lines_ok", 32'(d0_lok), 32'(0));
    rstn = 1'b1;

    // Full frame streamed back-to-back
    for (int i = 0; i < NL * LW; i++) begin
      cyc(1'b1, i + 1, 1'b0, 0, 1'b0, -1);
      chk("stream_wm_en", 32'(d1_wen), 32'(1));
      chk("stream_addr", 32'(d1_addr), 32'(i));
      chk("stream_data", 32'(d0_data), 32'(i + 1));
    end
    chk("stream_lines_ok", 32'(d1_lok), 32'(4));
    chk("stream_frame_done", 32'(d0_done), 32'(1));
    for (int q = 0; q < NL; q++) begin
      cyc(1'b0, 0, 1'b0, 0, 1'b0, q);
      chk("stream_received", 32'(d1_rp), 32'(1));
    end
    // Data while full is dropped; frame_rst with data clears and writes nothing
    cyc(1'b1, 12'h777, 1'b0, 0, 1'b0, -1);
    chk("full_no_write", 32'(d1_wen), 32'(0));
    chk("full_drop", 32'(d1_drop), 32'(1));
    cyc(1'b1, 12'h555, 1'b0, 0, 1'b1, -1);
    chk("frst_no_write", 32'(d0_wen), 32'(0));
    chk("frst_drop_clr", 32'(d1_drop), 32'(0));
    chk("frst_lines_ok", 32'(d1_lok), 32'(0));
    chk("frst_frame_done", 32'(d1_done), 32'(0));

    // Line 0 then silence: pad vs skip of line 1
    send_line(0, 12'h020);
    idle(WD);
    chk("to_pad_active", 32'(d1_pad), 32'(1));
    chk("to_skip_no_pad", 32'(d0_pad), 32'(0));
    for (int k = 0; k < LW; k++) begin
      idle(1);
      chk("pad_wm_en", 32'(d1_wen), 32'(1));
      chk("pad_addr", 32'(d1_addr), 32'(4 + k));
      chk("pad_data", 32'(d1_data), 32'(0));
      chk("skip_no_write", 32'(d0_wen), 32'(0));
    end
    chk("pad_over", 32'(d1_pad), 32'(0));
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1);
    chk("pad_line1_clear", 32'(d1_rp), 32'(0));
    chk("pad_lines_ok", 32'(d1_lok), 32'(1));
    chk("skip_line1_clear", 32'(d0_rp), 32'(0));
    send_line(8, 12'h100);

    // Header for line 2 aborts a pad of line 1
    cyc(1'b0, 0, 1'b0, 0, 1'b1, -1);
    send_line(0, 12'h040);
    idle(WD + 2);
    cyc(1'b0, 0, 1'b1, 2, 1'b0, -1);
    chk("abort_pad_off", 32'(d1_pad), 32'(0));
    cyc(1'b1, 12'hABC, 1'b0, 0, 1'b0, 1);
    chk("abort_addr", 32'(d1_addr), 32'(8));
    chk("abort_line1_clear", 32'(d1_rp), 32'(0));

    // Reset mid-line, then line 0 resent from address 0
    cyc(1'b0, 0, 1'b0, 0, 1'b1, -1);
    cyc(1'b1, 12'h0F1, 1'b0, 0, 1'b0, -1);
    cyc(1'b1, 12'h0F2, 1'b0, 0, 1'b0, -1);
    rstn = 1'b0;
    idle(1);
    chk("mid_rst_wm_en", 32'(d1_wen), 32'(0));
    chk("mid_rst_addr", 32'(d1_addr), 32'(0));
    rstn = 1'b1;
    send_line(0, 12'h0E0);

    // Random traffic with occasional headers, restarts and silent gaps
    begin
      int quiet = 0;
      for (int i = 0; i < 1500; i++) begin
        bit rv, lv, fr;
        if (quiet == 0 && $urandom_range(0, 99) < 3) quiet = $urandom_range(5, 16);
        lv = ($urandom_range(0, 99) < 3);
        fr = ($urandom_range(0, 199) < 2);
        rv = (quiet == 0) && !lv && ($urandom_range(0, 99) < 75);
        if (quiet > 0) quiet--;
        cyc(rv, int'($urandom_range(0, 4095)), lv, int'($urandom_range(0, NL - 1)), fr, -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
